// File: rtl/noc_pkg.sv
// Shared link constants, FSM state type and beat helper.
// Used by the serializer and the receiving deserializer.
package noc_pkg;

  localparam int FLIT_W = 64;
  localparam int LINK_W = 4;
  localparam int VC_W   = 2;
  localparam int BEATS  = FLIT_W / LINK_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Beat n of a flit; beats go out LS nibble first.
  function automatic logic [LINK_W-1:0] flit_beat(
    input logic [FLIT_W-1:0] flit,
    input int                n
  );
    return flit[n*LINK_W +: LINK_W];
  endfunction

endpackage

// File: rtl/ser_fifo.sv
// Synchronous FIFO, DEPTH x W, full/empty flags.
// Ports: clk, rst_n, wr_en/wr_data, rd_en/rd_data, full, empty.
module ser_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally: DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flit_serializer.sv
// Streams 64-bit flits as 16 4-bit link beats, LS nibble first.
// Ports: clk, rst_n, flit_in/vc_in/valid_in/ready_in (router side),
//   data_out/valid_out/vc_out (link), busy.
// SERIALIZER_STATS_EN adds flit_count[15:0] (flits sent, wrapping).
module flit_serializer
  import noc_pkg::*;
#(
  parameter int FLIT_W     = noc_pkg::FLIT_W,
  parameter int LINK_W     = noc_pkg::LINK_W,
  parameter int VC_W       = noc_pkg::VC_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              valid_in,
  input  logic [VC_W-1:0]   vc_in,
  output logic              ready_in,
  output logic [LINK_W-1:0] data_out,
  output logic              valid_out,
  output logic [VC_W-1:0]   vc_out,
  output logic              busy
`ifdef SERIALIZER_STATS_EN
  ,
  output logic [15:0]       flit_count
`endif
);

  localparam int NB     = FLIT_W / LINK_W;
  localparam int BEAT_W = $clog2(NB);
  localparam int EW     = FLIT_W + VC_W;

  ser_state_t        state;
  logic [FLIT_W-1:0] shreg;
  logic [BEAT_W-1:0] beat;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              last;
  logic              pop;

  ser_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (valid_in),
    .wr_data ({vc_in, flit_in}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Gated by rst_n so every output reads 0 during reset.
  assign ready_in = rst_n && !full;
  assign busy     = (state == SEND) || !empty;
  assign data_out = shreg[LINK_W-1:0];
  assign last     = (beat == BEAT_W'(NB - 1));
  assign pop      = !empty &&
                    ((state == IDLE) || last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      beat      <= '0;
      valid_out <= 1'b0;
      vc_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shreg     <= head[FLIT_W-1:0];
            vc_out    <= head[EW-1:FLIT_W];
            beat      <= '0;
            valid_out <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!last) begin
            shreg <= shreg >> LINK_W;
            beat  <= beat + 1'b1;
          end else if (!empty) begin
            // Back-to-back: next flit follows with no idle beat.
            shreg     <= head[FLIT_W-1:0];
            vc_out    <= head[EW-1:FLIT_W];
            beat      <= '0;
            valid_out <= 1'b1;
          end else begin
            shreg     <= '0;
            beat      <= '0;
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIALIZER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_count <= '0;
    end else if (state == SEND && last) begin
      flit_count <= flit_count + 16'd1;
    end
  end
`endif

endmodule
